// File: rtl/load_store_unit.sv
// Load/store unit: accepts one execute-stage memory request at a time, validates it,
// and sequences the data-memory bus through the synchronous-read cycle to writeback.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | req_ready high, waiting for a request
// ACCESS    | mem_en high, address/data presented, store written here
// LOAD_WAIT | mem_en held, memory output valid, captured at the edge
// DONE      | rsp_valid pulse with fault code, address and load data
module load_store_unit #(
  parameter logic [11:0] MAIN_REGION = 12'h800,
  parameter logic [11:0] SPEC_REGION = 12'h001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_fault,
  output logic [31:0] rsp_addr,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_se,
  output logic [1:0]  mem_bs,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    LOAD_WAIT = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_MAP   = 2'b10;
  localparam logic [1:0] FAULT_F3    = 2'b11;

  state_t      state_q, state_d;
  logic        accept;
  logic [31:0] ea;
  logic        f3_illegal;
  logic        misaligned;
  logic        unmapped;
  logic [1:0]  fault_d;
  logic [1:0]  bs_d;

  logic [31:0] ea_q;
  logic        store_q;
  logic [1:0]  fault_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  mem_bs_q;
  logic        mem_se_q;

  assign accept = req_valid && req_ready;
  assign ea     = req_base + req_offset;

  // Request decode and fault classification, evaluated combinationally on the request.
  always_comb begin
    f3_illegal = 1'b0;
    misaligned = 1'b0;
    unmapped   = 1'b0;
    fault_d    = FAULT_OK;
    bs_d       = 2'b11;

    if (req_store)
      f3_illegal = (req_funct3 >= 3'b011);
    else
      f3_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

    misaligned = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));

    unmapped = (ea[31:20] != MAIN_REGION) && (ea[31:20] != SPEC_REGION);

    if (f3_illegal)
      fault_d = FAULT_F3;
    else if (misaligned)
      fault_d = FAULT_ALIGN;
    else if (unmapped)
      fault_d = FAULT_MAP;

    case (req_funct3[1:0])
      2'b00:   bs_d = 2'b01;
      2'b01:   bs_d = 2'b10;
      default: bs_d = 2'b11;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = (fault_d != FAULT_OK) ? DONE : ACCESS;
      end
      ACCESS:    state_d = store_q ? DONE : LOAD_WAIT;
      LOAD_WAIT: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so it reads 0 for the whole reset window.
  always_comb begin
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:      req_ready = rst_n;
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = store_q;
      end
      LOAD_WAIT: mem_en = 1'b1;
      DONE:      rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Memory-side address/size/extension only move for requests that reach the bus,
  // so they keep their last driven values across faulting requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q        <= '0;
      store_q     <= 1'b0;
      fault_q     <= FAULT_OK;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bs_q    <= 2'b00;
      mem_se_q    <= 1'b0;
    end else begin
      if (accept) begin
        ea_q    <= ea;
        store_q <= req_store;
        fault_q <= fault_d;
        rdata_q <= '0;
        if (fault_d == FAULT_OK) begin
          mem_addr_q  <= ea;
          mem_wdata_q <= req_wdata;
          mem_bs_q    <= bs_d;
          mem_se_q    <= ~req_funct3[2];
        end
      end else if (state_q == LOAD_WAIT) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_bs    = mem_bs_q;
  assign mem_se    = mem_se_q;

  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;
  assign rsp_addr  = ea_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests against a small synchronous-read
// memory model, with a queue-based scoreboard checked by an independent monitor.
module tb_load_store_unit;

  localparam logic [31:0] ID_ADDR  = 32'h0010_0000;
  localparam logic [31:0] LED_ADDR = 32'h0010_0014;
  localparam logic [31:0] ID_VAL   = 32'h1D5E_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;
  logic [31:0] rsp_addr;
  logic        mem_en;
  logic        mem_we;
  logic        mem_se;
  logic [1:0]  mem_bs;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rsp_addr(rsp_addr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_se(mem_se), .mem_bs(mem_bs),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory model: byte-lane writes, registered read address, combinational extend.
  logic [31:0] ram [256] = '{default: 32'h0};
  logic [31:0] led_reg = 32'h0;
  logic [31:0] rd_addr_q = 32'h0;
  logic [31:0] rd_word, rd_sh;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      if (mem_addr[31:20] == 12'h800) begin
        case (mem_bs)
          2'b01:   ram[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
          2'b10:   ram[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
          default: ram[mem_addr[9:2]] <= mem_wdata;
        endcase
      end else if (mem_addr == LED_ADDR) begin
        led_reg <= mem_wdata;
      end
    end else if (mem_en) begin
      rd_addr_q <= mem_addr;
    end
  end

  always_comb begin
    rd_word   = 32'h0;
    rd_sh     = 32'h0;
    mem_rdata = 32'h0;
    if (rd_addr_q[31:20] == 12'h800) rd_word = ram[rd_addr_q[9:2]];
    else if (rd_addr_q == ID_ADDR)   rd_word = ID_VAL;
    else if (rd_addr_q == LED_ADDR)  rd_word = led_reg;
    rd_sh = rd_word >> {rd_addr_q[1:0], 3'b000};
    if (mem_en) begin
      case (mem_bs)
        2'b01:   mem_rdata = mem_se ? {{24{rd_sh[7]}}, rd_sh[7:0]} : {24'h0, rd_sh[7:0]};
        2'b10:   mem_rdata = mem_se ? {{16{rd_sh[15]}}, rd_sh[15:0]} : {16'h0, rd_sh[15:0]};
        default: mem_rdata = rd_sh;
      endcase
    end
  end

  typedef struct {
    string       name;
    logic [1:0]  fault;
    logic [31:0] rdata;
    logic [31:0] addr;
    int          lat;
    int          en_n;
    int          we_n;
    logic [1:0]  bs;
    logic        se;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   acc_log[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   issued = 0;
  int   resp_count = 0;
  int   en_cnt = 0;
  int   we_cnt = 0;
  logic [1:0] seen_bs = 2'b00;
  logic       seen_se = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: counts bus activity per request and checks each response against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0;
      we_cnt = 0;
    end else begin
      if (mem_en) begin
        en_cnt++;
        seen_bs = mem_bs;
        seen_se = mem_se;
      end
      if (mem_we) we_cnt++;
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rsp: actual=rsp_valid required=no response");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          resp_count++;
          check32({e.name, ".fault"}, 32'(rsp_fault), 32'(e.fault));
          check32({e.name, ".rdata"}, rsp_rdata, e.rdata);
          check32({e.name, ".addr"}, rsp_addr, e.addr);
          check32({e.name, ".latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
          check32({e.name, ".en_cycles"}, 32'(en_cnt), 32'(e.en_n));
          check32({e.name, ".we_cycles"}, 32'(we_cnt), 32'(e.we_n));
          if (e.en_n > 0) begin
            check32({e.name, ".bs"}, 32'(seen_bs), 32'(e.bs));
            check32({e.name, ".se"}, 32'(seen_se), 32'(e.se));
          end
        end
        en_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd,
                       input logic [1:0] xf, input logic [31:0] xr,
                       input logic hold, input string nm);
    exp_t e;
    int   guard;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL %s.accept_timeout: actual=req_ready 0 required=1", nm);
      req_valid = 1'b0;
      return;
    end
    e.name    = nm;
    e.fault   = xf;
    e.rdata   = xr;
    e.addr    = base + off;
    e.lat     = (xf != 2'b00) ? 1 : (st ? 2 : 3);
    e.en_n    = (xf != 2'b00) ? 0 : (st ? 1 : 2);
    e.we_n    = (xf == 2'b00 && st) ? 1 : 0;
    e.bs      = (f3[1:0] == 2'b00) ? 2'b01 : (f3[1:0] == 2'b01) ? 2'b10 : 2'b11;
    e.se      = ~f3[2];
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    acc_log.push_back(cyc);
    issued++;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s.drain_timeout: actual=%0d pending required=0", nm, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_base   = 32'h0;
    req_offset = 32'h0;
    req_wdata  = 32'h0;

    #12;
    check32("reset.req_ready", 32'(req_ready), 32'h0);
    check32("reset.mem_en", 32'(mem_en), 32'h0);
    check32("reset.rsp_valid", 32'(rsp_valid), 32'h0);
    check32("reset.rsp_rdata", rsp_rdata, 32'h0);
    check32("reset.mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check32("reset.ready_after", 32'(req_ready), 32'h1);

    // SW then LW of the same word
    issue(1'b1, 3'b010, 32'h8000_0000, 32'h8, 32'hDEAD_BEEF, 2'b00, 32'h0, 1'b0, "sw_main");
    drain("sw_main");
    issue(1'b0, 3'b010, 32'h8000_0000, 32'h8, 32'h0, 2'b00, 32'hDEAD_BEEF, 1'b0, "lw_main");
    drain("lw_main");

    // Byte store into lane 3 then signed/unsigned byte and half reads
    issue(1'b1, 3'b000, 32'h8000_0010, 32'h3, 32'h1234_56A5, 2'b00, 32'h0, 1'b0, "sb");
    drain("sb");
    issue(1'b0, 3'b000, 32'h8000_0010, 32'h3, 32'h0, 2'b00, 32'hFFFF_FFA5, 1'b0, "lb");
    drain("lb");
    issue(1'b0, 3'b100, 32'h8000_0010, 32'h3, 32'h0, 2'b00, 32'h0000_00A5, 1'b0, "lbu");
    drain("lbu");
    issue(1'b0, 3'b001, 32'h8000_0010, 32'h2, 32'h0, 2'b00, 32'hFFFF_A500, 1'b0, "lh");
    drain("lh");
    issue(1'b0, 3'b101, 32'h8000_0010, 32'h2, 32'h0, 2'b00, 32'h0000_A500, 1'b0, "lhu");
    drain("lhu");
    issue(1'b0, 3'b010, 32'h8000_0020, 32'hFFFF_FFF0, 32'h0, 2'b00, 32'hA500_0000, 1'b0, "lw_negoff");
    drain("lw_negoff");

    // Faults, including priority between simultaneous conditions
    issue(1'b0, 3'b001, 32'h8000_0000, 32'h1, 32'h0, 2'b01, 32'h0, 1'b0, "lh_misal");
    drain("lh_misal");
    issue(1'b0, 3'b010, 32'h8000_0000, 32'h2, 32'h0, 2'b01, 32'h0, 1'b0, "lw_misal");
    drain("lw_misal");
    issue(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 2'b11, 32'h0, 1'b0, "ld_f3_011");
    drain("ld_f3_011");
    issue(1'b1, 3'b010, 32'h2000_0000, 32'h0, 32'h5555_5555, 2'b10, 32'h0, 1'b0, "sw_unmapped");
    drain("sw_unmapped");
    issue(1'b1, 3'b100, 32'h8000_0000, 32'h0, 32'h5555_5555, 2'b11, 32'h0, 1'b0, "st_f3_100");
    drain("st_f3_100");
    issue(1'b0, 3'b111, 32'h8000_0000, 32'h1, 32'h0, 2'b11, 32'h0, 1'b0, "f3_over_misal");
    drain("f3_over_misal");
    issue(1'b0, 3'b010, 32'h2000_0000, 32'h2, 32'h0, 2'b01, 32'h0, 1'b0, "misal_over_map");
    drain("misal_over_map");
    issue(1'b1, 3'b010, 32'h8000_0000, 32'h9, 32'h1111_1111, 2'b01, 32'h0, 1'b0, "sw_misal_ram");
    drain("sw_misal_ram");
    issue(1'b0, 3'b010, 32'h8000_0000, 32'h8, 32'h0, 2'b00, 32'hDEAD_BEEF, 1'b0, "lw_unchanged");
    drain("lw_unchanged");

    // Special region: LED register and ID register
    issue(1'b1, 3'b010, 32'h0010_0000, 32'h14, 32'h0000_F0F0, 2'b00, 32'h0, 1'b0, "sw_led");
    drain("sw_led");
    check32("led_out", led_reg, 32'h0000_F0F0);
    issue(1'b0, 3'b010, 32'h0010_0000, 32'h14, 32'h0, 2'b00, 32'h0000_F0F0, 1'b0, "lw_led");
    drain("lw_led");
    issue(1'b0, 3'b010, 32'h0010_0000, 32'h0, 32'h0, 2'b00, ID_VAL, 1'b0, "lw_id");
    drain("lw_id");

    // Reset asserted during LOAD_WAIT aborts the request
    issue(1'b0, 3'b010, 32'h8000_0000, 32'h8, 32'h0, 2'b00, 32'hDEAD_BEEF, 1'b0, "lw_abort");
    @(posedge clk);
    #2;
    check32("abort.in_load_wait_en", 32'(mem_en), 32'h1);
    rst_n = 1'b0;
    #1;
    check32("abort.mem_en", 32'(mem_en), 32'h0);
    check32("abort.rsp_valid", 32'(rsp_valid), 32'h0);
    void'(sb_q.pop_back());
    issued--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check32("abort.ready_after", 32'(req_ready), 32'h1);
    issue(1'b0, 3'b010, 32'h8000_0000, 32'h8, 32'h0, 2'b00, 32'hDEAD_BEEF, 1'b0, "lw_after_rst");
    drain("lw_after_rst");

    // Continuous req_valid with alternating SW/LW
    acc_log.delete();
    issue(1'b1, 3'b010, 32'h8000_0040, 32'h0, 32'h0102_0304, 2'b00, 32'h0, 1'b1, "bb_sw0");
    issue(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h0, 2'b00, 32'h0102_0304, 1'b1, "bb_lw0");
    issue(1'b1, 3'b010, 32'h8000_0044, 32'h0, 32'hCAFE_F00D, 2'b00, 32'h0, 1'b1, "bb_sw1");
    issue(1'b0, 3'b010, 32'h8000_0044, 32'h0, 32'h0, 2'b00, 32'hCAFE_F00D, 1'b0, "bb_lw1");
    drain("bb");
    if (acc_log.size() == 4) begin
      check32("bb.sw_interval", 32'(acc_log[1] - acc_log[0]), 32'd3);
      check32("bb.lw_interval", 32'(acc_log[2] - acc_log[1]), 32'd4);
      check32("bb.sw_interval2", 32'(acc_log[3] - acc_log[2]), 32'd3);
    end else begin
      check32("bb.accept_count", 32'(acc_log.size()), 32'd4);
    end

    check32("rsp_count", 32'(resp_count), 32'(issued));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory bus: accepts one load/store request at a time from the execute stage and computes the effective address.
- Checks alignment, region and funct3, then drives the data memory's mem_en/mem_we/mem_se/mem_bs/addr/data_in signals.
- Holds the request stable across the memory's synchronous-read cycle, captures the returned word and reports completion or a fault to writeback.
- Sits between the execute stage and the data memory.

Parameters:
- MAIN_REGION, 12'h800, addr[31:20] value selecting main RAM.
- SPEC_REGION, 12'h001, addr[31:20] value selecting the special/I/O registers.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
- req_base  input  32  rs1 value.
- req_offset  input  32  sign-extended immediate.
- req_wdata  input  32  rs2 value (store data, right-aligned).
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  extended load result; valid with rsp_valid.
- rsp_fault  output  2  00 ok, 01 misaligned, 10 unmapped region, 11 illegal funct3.
- rsp_addr  output  32  effective address of the completed request.
- mem_en, mem_we, mem_se  output  1 each  to data memory.
- mem_bs  output  2  01 byte, 10 half, 11 word.
- mem_addr  output  32  to data memory addr.
- mem_wdata  output  32  to data memory data_in.
- mem_rdata  input  32  from data memory data_out (combinational on addr/bs/se/en, one-cycle read latency).

Behaviour:
- Reset:
  - state IDLE.
  - All outputs 0, except req_ready = 1 once rst_n is high.
  - Reset mid-operation aborts the request: mem_en drops immediately (async), no rsp_valid is issued, and a write already sampled by memory persists.
- Accept: on the edge where req_valid && req_ready, register the following; req_ready is then 0 until IDLE:
  - ea = req_base + req_offset (mod 2^32).
  - req_store and req_wdata.
  - mem_bs = 01/10/11 for funct3[1:0] = 00/01/10.
  - mem_se = ~funct3[2].
- Fault check at acceptance (priority order):
  - Illegal funct3 → 11. Illegal codes: loads 011/110/111; stores any funct3 ≥ 011.
  - Misaligned → 01: half with ea[0] = 1, or word with ea[1:0] ≠ 00.
  - ea[31:20] ∉ {MAIN_REGION, SPEC_REGION} → 10.
  - A faulting request goes straight to DONE; mem_en is never asserted.
- States:
  - IDLE: req_ready = 1.
  - ACCESS, one cycle: mem_en = 1, mem_we = req_store, mem_addr = ea, mem_wdata = wdata. Store → DONE; load → LOAD_WAIT.
  - LOAD_WAIT, one cycle: mem_en = 1, mem_we = 0, same addr/bs/se (keeps the memory's output mux and extension selection valid). At the edge: rsp_rdata ← mem_rdata → DONE.
  - DONE, one cycle: rsp_valid = 1; rsp_fault, rsp_addr = ea and rsp_rdata held → IDLE.
- Latency, counted in edges from the acceptance edge to rsp_valid high:
  - Store: 2 edges.
  - Load: 3 edges.
  - Fault: 1 edge.
  - Back-to-back throughput: one request per 3 cycles for stores, one per 4 cycles for loads.
- Outside ACCESS/LOAD_WAIT:
  - mem_en = 0 and mem_we = 0.
  - mem_addr, mem_bs and mem_se keep their last values.
- rsp_rdata on a store or fault is 0.
- req_valid ignored while not IDLE; requester must hold request until accepted.
- mem_we is never 1 outside ACCESS; no memory write is issued for any faulting request.

Test Plan:
- SW base=0x80000000, off=8, wdata=0xDEADBEEF, then LW same ea → store rsp_valid 2 edges after accept with fault 00; load rsp_rdata=0xDEADBEEF after 3 edges; mem_en high exactly 1 cycle for the store and 2 cycles for the load.
- SB 0xA5 to 0x80000013, then LB and LBU of 0x80000013 → 0xFFFFFFA5 and 0x000000A5, with mem_bs=01 and mem_se 1 then 0.
- LH ea=0x80000001, LW ea=0x80000002, load funct3=011, SW ea=0x20000000 → faults 01/01/11/10; rsp_valid 1 edge after accept; mem_en never asserts; RAM contents unchanged.
- SW 0x0000F0F0 to 0x00100014, then LW 0x00100014 → led_out=0xF0F0 and readback 0x0000F0F0; LW 0x00100000 returns the ID register value.
- Assert rst_n low during LOAD_WAIT → mem_en=0 and rsp_valid=0 immediately, state IDLE, req_ready=1 after release; a fresh LW completes normally.
- Hold req_valid high continuously with alternating SW/LW → each accepted only in IDLE; exactly one rsp_valid per request; order preserved.
